// File: rtl/rv32e_decode_stage_if.sv
// Fetch-to-ALU decode bus: raw instruction in, decoded control word out.
// The decoder takes the slave modport; the producer/consumer side takes master.
interface rv32e_decode_stage_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_op_sel;
    logic [31:0] out_imm;
    logic [3:0]  out_rs1;
    logic [3:0]  out_rs2;
    logic [3:0]  out_rd;
    logic        out_rd_we;
    logic [31:0] out_pc;
    logic        out_illegal;

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_op_sel, out_imm, out_rs1, out_rs2,
               out_rd, out_rd_we, out_pc, out_illegal
    );

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_op_sel, out_imm, out_rs1, out_rs2,
               out_rd, out_rd_we, out_pc, out_illegal
    );
endinterface

// File: rtl/rv32e_decode_stage.sv
// RV32E decoder: same-cycle decode into an output register backed by a skid
// register, so backpressure never stalls the accept path combinationally.
module rv32e_decode_stage (
    input  logic                  clk,
    input  logic                  rst,
    rv32e_decode_stage_if.slave   bus
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_ADDI  = 5'd9;
    localparam logic [4:0] OP_ANDI  = 5'd10;
    localparam logic [4:0] OP_ORI   = 5'd11;
    localparam logic [4:0] OP_XORI  = 5'd12;
    localparam logic [4:0] OP_SLLI  = 5'd13;
    localparam logic [4:0] OP_SRLI  = 5'd14;
    localparam logic [4:0] OP_SRAI  = 5'd15;
    localparam logic [4:0] OP_SLTI  = 5'd16;
    localparam logic [4:0] OP_BEQ   = 5'd17;
    localparam logic [4:0] OP_BNE   = 5'd18;
    localparam logic [4:0] OP_BLT   = 5'd19;
    localparam logic [4:0] OP_BGE   = 5'd20;
    localparam logic [4:0] OP_LUI   = 5'd21;
    localparam logic [4:0] OP_AUIPC = 5'd22;
    localparam logic [4:0] OP_JAL   = 5'd23;
    localparam logic [4:0] OP_JALR  = 5'd24;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [4:0]  op_sel;
        logic [31:0] imm;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic        rd_we;
        logic [31:0] pc;
        logic        illegal;
    } dec_word_t;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_sh;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;

    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_sh = {27'd0, inst[24:20]};
    assign imm_b  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u  = {inst[31:12], 12'd0};

    logic       legal;
    logic       use_rs1;
    logic       use_rs2;
    logic       use_rd;
    logic       reg_bad;
    logic       is_illegal;
    logic [4:0] op_raw;
    logic [31:0] imm_raw;
    dec_word_t  dec;

    always_comb begin
        legal   = 1'b1;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        op_raw  = OP_ADD;
        imm_raw = 32'd0;
        case (opcode)
            OPC_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                // funct7 0x20 is only meaningful for SUB and SRA
                if (!((funct7 == 7'h00) ||
                      (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    legal = 1'b0;
                case (funct3)
                    3'b000:  op_raw = funct7[5] ? OP_SUB : OP_ADD;
                    3'b001:  op_raw = OP_SLL;
                    3'b010:  op_raw = OP_SLT;
                    3'b100:  op_raw = OP_XOR;
                    3'b101:  op_raw = funct7[5] ? OP_SRA : OP_SRL;
                    3'b110:  op_raw = OP_OR;
                    3'b111:  op_raw = OP_AND;
                    default: legal  = 1'b0;
                endcase
            end
            OPC_I: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm_raw = imm_i;
                case (funct3)
                    3'b000: op_raw = OP_ADDI;
                    3'b001: begin
                        op_raw  = OP_SLLI;
                        imm_raw = imm_sh;
                        if (funct7 != 7'h00) legal = 1'b0;
                    end
                    3'b010: op_raw = OP_SLTI;
                    3'b100: op_raw = OP_XORI;
                    3'b101: begin
                        imm_raw = imm_sh;
                        if (funct7 == 7'h00)      op_raw = OP_SRLI;
                        else if (funct7 == 7'h20) op_raw = OP_SRAI;
                        else                      legal  = 1'b0;
                    end
                    3'b110:  op_raw = OP_ORI;
                    3'b111:  op_raw = OP_ANDI;
                    default: legal  = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_raw = imm_b;
                case (funct3)
                    3'b000:  op_raw = OP_BEQ;
                    3'b001:  op_raw = OP_BNE;
                    3'b100:  op_raw = OP_BLT;
                    3'b101:  op_raw = OP_BGE;
                    default: legal  = 1'b0;
                endcase
            end
            OPC_LUI: begin
                use_rd  = 1'b1;
                op_raw  = OP_LUI;
                imm_raw = imm_u;
            end
            OPC_AUIPC: begin
                use_rd  = 1'b1;
                op_raw  = OP_AUIPC;
                imm_raw = imm_u;
            end
            OPC_JAL: begin
                use_rd  = 1'b1;
                op_raw  = OP_JAL;
                imm_raw = imm_j;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                op_raw  = OP_JALR;
                imm_raw = imm_i;
                if (funct3 != 3'b000) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (inst[1:0] != 2'b11) legal = 1'b0;

        // RV32E has x0-x15 only: bit 4 of any consulted register field traps
        reg_bad    = (use_rs1 & inst[19]) | (use_rs2 & inst[24]) | (use_rd & inst[11]);
        is_illegal = ~legal | reg_bad;

        dec         = '0;
        dec.rs1     = inst[18:15];
        dec.rs2     = inst[23:20];
        dec.rd      = inst[10:7];
        dec.pc      = bus.in_pc;
        dec.illegal = is_illegal;
        dec.op_sel  = is_illegal ? OP_ADD : op_raw;
        dec.imm     = is_illegal ? 32'd0 : imm_raw;
        dec.rd_we   = use_rd & ~is_illegal & (inst[11:7] != 5'd0);
    end

    // Handshake: a word transfers on any rising edge where valid & ready are
    // both high; valid never depends on ready, and in_ready is ~S.valid only.
    dec_word_t o_q;
    dec_word_t s_q;
    logic      o_valid;
    logic      s_valid;
    logic      accept;
    logic      o_free;

    assign accept = bus.in_valid & ~s_valid;
    assign o_free = ~o_valid | bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q     <= '0;
            s_q     <= '0;
            o_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (bus.flush) begin
            o_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (o_free) begin
            if (s_valid) begin
                o_q     <= s_q;
                o_valid <= 1'b1;
                s_valid <= accept;
                if (accept) s_q <= dec;
            end else begin
                o_valid <= accept;
                if (accept) o_q <= dec;
            end
        end else if (accept) begin
            s_q     <= dec;
            s_valid <= 1'b1;
        end
    end

    assign bus.in_ready    = ~s_valid;
    assign bus.out_valid   = o_valid;
    assign bus.out_op_sel  = o_q.op_sel;
    assign bus.out_imm     = o_q.imm;
    assign bus.out_rs1     = o_q.rs1;
    assign bus.out_rs2     = o_q.rs2;
    assign bus.out_rd      = o_q.rd;
    assign bus.out_rd_we   = o_q.rd_we;
    assign bus.out_pc      = o_q.pc;
    assign bus.out_illegal = o_q.illegal;

endmodule

// File: tb/tb_rv32e_decode_stage.sv
// Directed bench for rv32e_decode_stage: decode vectors, backpressure,
// flush and asynchronous reset, with immediate assertions at each check.
module tb_rv32e_decode_stage;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    rv32e_decode_stage_if bus ();

    rv32e_decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = v;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
    endtask

    task automatic dec_check(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                             input logic [4:0] op, input logic [31:0] imm,
                             input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                             input logic we, input logic ill);
        bus.out_ready = 1'b1;
        drive(1'b1, inst, pc);
        step();
        drive(1'b0, 32'd0, 32'd0);
        check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, ".op"}, {27'd0, bus.out_op_sel}, {27'd0, op});
        check({tag, ".imm"}, bus.out_imm, imm);
        check({tag, ".rs1"}, {28'd0, bus.out_rs1}, {28'd0, rs1});
        check({tag, ".rs2"}, {28'd0, bus.out_rs2}, {28'd0, rs2});
        check({tag, ".rd"}, {28'd0, bus.out_rd}, {28'd0, rd});
        check({tag, ".we"}, {31'd0, bus.out_rd_we}, {31'd0, we});
        check({tag, ".ill"}, {31'd0, bus.out_illegal}, {31'd0, ill});
        check({tag, ".pc"}, bus.out_pc, pc);
        step();
        check({tag, ".drain"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        step();
        step();
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst.out_pc", bus.out_pc, 32'd0);
        check("rst.out_imm", bus.out_imm, 32'd0);
        check("rst.out_illegal", {31'd0, bus.out_illegal}, 32'd0);
        #3 rst = 1'b0;
        step();

        // decode vectors
        dec_check("add",   32'h002081B3, 32'h0000_0010, 5'd0,  32'h0,        4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
        dec_check("sub",   32'h407302B3, 32'h0000_0014, 5'd1,  32'h0,        4'd6, 4'd7, 4'd5, 1'b1, 1'b0);
        dec_check("lui",   32'h123450B7, 32'h0000_0018, 5'd21, 32'h12345000, 4'd8, 4'd3, 4'd1, 1'b1, 1'b0);
        dec_check("beq",   32'hFE208CE3, 32'h0000_001C, 5'd17, 32'hFFFFFFF8, 4'd1, 4'd2, 4'd9, 1'b0, 1'b0);
        dec_check("addi",  32'hFFF00093, 32'h0000_0020, 5'd9,  32'hFFFFFFFF, 4'd0, 4'hF, 4'd1, 1'b1, 1'b0);
        dec_check("srai",  32'h4030D113, 32'h0000_0024, 5'd15, 32'h00000003, 4'd1, 4'd3, 4'd2, 1'b1, 1'b0);
        dec_check("jal",   32'hFFDFF0EF, 32'h0000_0028, 5'd23, 32'hFFFFFFFC, 4'hF, 4'hD, 4'd1, 1'b1, 1'b0);
        dec_check("add_x0",32'h00208033, 32'h0000_002C, 5'd0,  32'h0,        4'd1, 4'd2, 4'd0, 1'b0, 1'b0);
        dec_check("x16",   32'h00208833, 32'h0000_0030, 5'd0,  32'h0,        4'd1, 4'd2, 4'd0, 1'b0, 1'b1);
        dec_check("sltu",  32'h0020B1B3, 32'h0000_0034, 5'd0,  32'h0,        4'd1, 4'd2, 4'd3, 1'b0, 1'b1);
        dec_check("lw",    32'h0000A083, 32'h0000_0038, 5'd0,  32'h0,        4'd1, 4'd0, 4'd1, 1'b0, 1'b1);
        dec_check("lowbits",32'h002081B2,32'h0000_003C, 5'd0,  32'h0,        4'd1, 4'd2, 4'd3, 1'b0, 1'b1);

        // backpressure: A, B, C with out_ready low for two cycles after A
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h00100093, 32'h100);
        step();
        check("bp.a_out", bus.out_pc, 32'h100);
        check("bp.a_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00200113, 32'h104);
        step();
        check("bp.hold1_pc", bus.out_pc, 32'h100);
        check("bp.hold1_imm", bus.out_imm, 32'd1);
        check("bp.in_ready_low1", {31'd0, bus.in_ready}, 32'd0);
        drive(1'b1, 32'h00300193, 32'h108);
        step();
        check("bp.hold2_pc", bus.out_pc, 32'h100);
        check("bp.in_ready_low2", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        step();
        check("bp.b_pc", bus.out_pc, 32'h104);
        check("bp.b_imm", bus.out_imm, 32'd2);
        check("bp.in_ready_back", {31'd0, bus.in_ready}, 32'd1);
        step();
        drive(1'b0, 32'd0, 32'd0);
        check("bp.c_pc", bus.out_pc, 32'h108);
        check("bp.c_imm", bus.out_imm, 32'd3);
        check("bp.c_rd", {28'd0, bus.out_rd}, 32'd3);
        step();
        check("bp.empty", {31'd0, bus.out_valid}, 32'd0);

        // flush with O and S full and a word presented
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h200);
        step();
        drive(1'b1, 32'h00200113, 32'h204);
        step();
        check("fl.s_full", {31'd0, bus.in_ready}, 32'd0);
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h00300193, 32'h208);
        step();
        bus.flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        check("fl.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("fl.in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        check("fl.no_word", {31'd0, bus.out_valid}, 32'd0);

        // flush while in_ready=1: the word offered in that cycle is dropped
        drive(1'b1, 32'h00100093, 32'h300);
        step();
        bus.flush = 1'b1;
        drive(1'b1, 32'h00200113, 32'h304);
        step();
        bus.flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        check("fl2.out_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("fl2.dropped", {31'd0, bus.out_valid}, 32'd0);

        // asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h400);
        step();
        drive(1'b1, 32'h00200113, 32'h404);
        step();
        drive(1'b0, 32'd0, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("arst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("arst.out_pc", bus.out_pc, 32'd0);
        #2 rst = 1'b0;
        step();
        check("arst.still_empty", {31'd0, bus.out_valid}, 32'd0);
        dec_check("post_rst", 32'h002081B3, 32'h0000_0500, 5'd0, 32'h0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rv32e_decode_stage.md
# rv32e_decode_stage

Pipelined RV32E instruction decoder sitting between fetch and the ALU. It accepts raw 32-bit instructions with their PC over a valid/ready handshake and produces the ALU-facing control word: `op_sel`, an immediate in final form, register indices and write enable. It buffers through a 2-entry skid register so full throughput is kept under downstream backpressure. It flags anything the ALU cannot execute as illegal.

## Interface
- No parameters.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `flush` input 1: synchronous pipeline flush.
- `in_valid` input 1: upstream instruction valid.
- `in_ready` output 1: decoder can accept.
- `in_inst` input 32: instruction word.
- `in_pc` input 32: instruction address.
- `out_valid` output 1: decoded word valid.
- `out_ready` input 1: downstream accepts.
- `out_op_sel` output 5: ALU operation code.
- `out_imm` output 32: immediate, final form.
- `out_rs1`, `out_rs2`, `out_rd` output 4 each: register indices.
- `out_rd_we` output 1: register write enable.
- `out_pc` output 32: PC of the instruction.
- `out_illegal` output 1: instruction not executable.

## Operation
- **op_sel codes:**
  - ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8.
  - ADDI 9, ANDI 10, ORI 11, XORI 12, SLLI 13, SRLI 14, SRAI 15, SLTI 16.
  - BEQ 17, BNE 18, BLT 19, BGE 20.
  - LUI 21, AUIPC 22, JAL 23, JALR 24.
- **Immediates:**
  - I-type: sign-extended inst[31:20].
  - Shifts: zero-extended shamt inst[24:20].
  - B-type and J-type: sign-extended byte offsets, bit0 = 0.
  - LUI/AUIPC: {inst[31:12],12'b0}. The shift is applied here, not in the ALU.
  - R-type: imm = 0.
- **Register indices:**
  - rs1 = inst[18:15], rs2 = inst[23:20], rd = inst[10:7].
  - Unused fields are still passed through as those bit slices.
- **rd_we:**
  - 1 for R, I, U, JAL, JALR when rd != 0.
  - 0 for branches, for rd == 0, and for illegal instructions.
- **Illegal (out_illegal=1, op_sel=0, imm=0, rd_we=0):**
  - Any used register field with bit 4 set (x16–x31).
  - SLTU, SLTIU, BLTU, BGEU.
  - Loads, stores, FENCE, SYSTEM, unknown opcodes.
  - inst[1:0] != 2'b11.
  - R-type funct7 other than 0x00, or 0x20 with ADD/SRL.
  - SLLI/SRLI with inst[31:25] != 0; SRAI with inst[31:25] != 0x20.
  - JALR with funct3 != 0.
- **Illegal passthrough:** illegal words still flow through in order, so the PC is available for the trap.
- **Buffering:**
  - Output register O (drives out_*) and skid register S.
  - `in_ready` = ~S.valid, driven from a register and never combinational from out_ready.
  - Accept (`in_valid & in_ready`):
    - If O is empty, or O is being consumed with S empty, the decoded word loads O.
    - Otherwise it loads S.
  - When O is consumed and S is full, S moves to O. If an accept happens in the same cycle, the new word loads S.
  - Order is strictly preserved.
- **Flush** (highest priority after reset):
  - Clears O.valid and S.valid.
  - A word accepted in the flush cycle is dropped.
  - in_ready = 1 next cycle.

## Timing
- **Reset values:** out_valid=0, in_ready=1, all data outputs 0, O/S empty.
- **Reset mid-operation:** buffered words are discarded immediately and asynchronously.
- **Latency:** word accepted at edge N appears on out_* with out_valid=1 after edge N (same-cycle decode, one register stage).
- **Throughput:** 1 word/cycle while out_ready=1.
- **Stable outputs:** while out_valid & ~out_ready, all out_* hold stable.
- **Backpressure onset:**
  - out_ready low for one cycle with a stream in flight: S fills, in_ready=0 the following cycle.
  - After out_ready returns high: in_ready=1 one cycle after S drains.
- **Simultaneous flush and out_ready:** the flush wins. Downstream sees out_valid drop next cycle; the current word counts as consumed if out_ready was high.

## Test plan
- **Decode R-type:**
  - 0x002081B3 (ADD x3,x1,x2) -> op 0, rs1 1, rs2 2, rd 3, rd_we 1, imm 0.
  - 0x407302B3 -> op 1, rd 5.
- **U/B-type immediates:**
  - 0x123450B7 -> op 21, imm 0x12345000, rd 1.
  - 0xFE208CE3 (BEQ x1,x2,-8) -> op 17, imm 0xFFFFFFF8, rd_we 0.
- **Illegal:**
  - 0x00208833 (rd=x16) -> out_illegal 1, op 0, rd_we 0.
  - SLTU 0x0020B1B3 -> illegal.
  - LW 0x0000A083 -> illegal.
- **Backpressure:**
  - Stream A, B, C with out_ready low for 2 cycles after A is presented.
  - in_ready drops after B is accepted; A is held stable.
  - A, B, C emerge in order with no loss or duplication.
- **Flush:** with O and S full, assert flush with in_valid high -> next cycle out_valid 0, in_ready 1, the flush-cycle word is never output.
- **Async reset:** assert rst between clock edges mid-stream -> out_valid 0 and in_ready 1 immediately; decode resumes correctly after release.
